// File: rtl/mchange_dispenser.sv
// mchange_dispenser: greedy tens-first change return, pulsing the ten- and one-unit hopper eject lines.
module mchange_dispenser #(
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2,
  parameter int TEN_VALUE = 10
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic             ten_empty,
  input  logic             one_empty,
  output logic             tensig,
  output logic             onesig,
  output logic             busy,
  output logic [WIDTH-1:0] remain,
  output logic             done,
  output logic             fault
);
  typedef enum logic [2:0] {IDLE, PICK, PULSE, GAP, DONE, FAULT} state_t;
  localparam int CW = $clog2((PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC) + 1);
  state_t           r_state, w_nxt;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [WIDTH-1:0] r_remain, w_remain;
  logic             r_sel, w_sel;
  logic             r_tensig, r_onesig, r_busy, r_done, r_fault;
  always_comb begin
    w_nxt    = r_state;
    w_cnt    = r_cnt;
    w_remain = r_remain;
    w_sel    = r_sel;
    unique case (r_state)
      IDLE, FAULT: if (start) begin
        w_remain = amount;
        w_nxt    = (amount != '0) ? PICK : DONE;
      end
      PICK: begin
        w_cnt = '0;
        if (r_remain >= WIDTH'(TEN_VALUE) && !ten_empty) begin
          w_sel = 1'b1;
          w_nxt = PULSE;
        end else if (r_remain != '0 && !one_empty) begin
          w_sel = 1'b0;
          w_nxt = PULSE;
        end else
          w_nxt = (r_remain == '0) ? DONE : FAULT;
      end
      // the coin is only charged once its pulse has completed
      PULSE: if (r_cnt == CW'(PULSE_CYC - 1)) begin
        w_cnt    = '0;
        w_remain = r_remain - (r_sel ? WIDTH'(TEN_VALUE) : WIDTH'(1));
        w_nxt    = GAP;
      end else
        w_cnt = r_cnt + CW'(1);
      GAP: if (r_cnt == CW'(GAP_CYC - 1)) begin
        w_cnt = '0;
        w_nxt = PICK;
      end else
        w_cnt = r_cnt + CW'(1);
      DONE: begin
        w_remain = '0;
        w_nxt    = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they align with r_state
  always_ff @(posedge cp or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_remain <= '0;
      r_sel    <= 1'b0;
      r_tensig <= 1'b0;
      r_onesig <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt;
      r_remain <= w_remain;
      r_sel    <= w_sel;
      r_tensig <= (w_nxt == PULSE) && w_sel;
      r_onesig <= (w_nxt == PULSE) && !w_sel;
      r_busy   <= (w_nxt == PICK) || (w_nxt == PULSE) || (w_nxt == GAP);
      r_done   <= (w_nxt == DONE);
      r_fault  <= (w_nxt == FAULT);
    end
  end
  assign tensig = r_tensig;
  assign onesig = r_onesig;
  assign busy   = r_busy;
  assign remain = r_remain;
  assign done   = r_done;
  assign fault  = r_fault;
endmodule

// File: tb/tb_mchange_dispenser.sv
// tb_mchange_dispenser: directed refund sequences checked cycle by cycle against hand-derived masks.
module tb_mchange_dispenser;
  logic        cp = 1'b0, rst = 1'b0, start = 1'b0, ten_empty = 1'b0, one_empty = 1'b0;
  logic [7:0]  amount = '0;
  logic        tensig, onesig, busy, done, fault;
  logic [7:0]  remain;
  int          vectors = 0, errs = 0;
  logic [127:0] ten_m, one_m, done_m, busy_m, fault_m;
  logic [7:0]  rem_a [128];
  logic        acc;
  mchange_dispenser dut (
    .cp(cp), .rst(rst), .start(start), .amount(amount),
    .ten_empty(ten_empty), .one_empty(one_empty),
    .tensig(tensig), .onesig(onesig), .busy(busy),
    .remain(remain), .done(done), .fault(fault)
  );
  always #5 cp = ~cp;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // bit k of each mask is the output sampled just after edge k, edge 0 being the start edge
  task automatic refund(input logic [7:0] amt, input int n, input int poke);
    ten_m = '0; one_m = '0; done_m = '0; busy_m = '0; fault_m = '0;
    @(negedge cp);
    start = 1'b1;
    amount = amt;
    for (int k = 0; k < n; k++) begin
      @(posedge cp);
      #1;
      ten_m[k] = tensig; one_m[k] = onesig; done_m[k] = done;
      busy_m[k] = busy; fault_m[k] = fault; rem_a[k] = remain;
      start = (k == poke);
      if (k == poke) amount = 8'd7;
    end
  endtask
  task automatic check23(input string p);
    check({p, "_ten"}, ten_m, 128'hC6);
    check({p, "_one"}, one_m, 128'h631800);
    check({p, "_done"}, done_m, 128'h4000000);
    check({p, "_busy"}, busy_m, 128'h3FFFFFF);
    check({p, "_rem2"}, 128'(rem_a[2]), 128'd23);
    check({p, "_rem3"}, 128'(rem_a[3]), 128'd13);
    check({p, "_rem8"}, 128'(rem_a[8]), 128'd3);
    check({p, "_rem13"}, 128'(rem_a[13]), 128'd2);
    check({p, "_rem18"}, 128'(rem_a[18]), 128'd1);
    check({p, "_rem23"}, 128'(rem_a[23]), 128'd0);
    check({p, "_rem27"}, 128'(rem_a[27]), 128'd0);
  endtask
  initial begin
    #12;
    check("rst_outs", 128'({tensig, onesig, busy, done, fault, remain}), 128'd0);
    @(negedge cp);
    rst = 1'b1;
    acc = 1'b0;
    repeat (5) begin
      @(posedge cp);
      #1;
      acc = acc | tensig | onesig | busy | done | fault;
    end
    check("idle_quiet", 128'(acc), 128'd0);
    refund(8'd23, 30, -1);
    check23("a23");
    ten_empty = 1'b1;
    refund(8'd12, 70, -1);
    check("a12_ten", ten_m, 128'd0);
    check("a12_onecnt", 128'($countones(one_m)), 128'd24);
    check("a12_done", done_m, 128'd1 << 61);
    ten_empty = 1'b0;
    one_empty = 1'b1;
    refund(8'd15, 10, -1);
    check("a15_ten", ten_m, 128'h6);
    check("a15_one", one_m, 128'd0);
    check("a15_fault", fault_m, 128'h3C0);
    check("a15_busy9", 128'(busy_m[9]), 128'd0);
    check("a15_rem", 128'(rem_a[9]), 128'd5);
    one_empty = 1'b0;
    acc = 1'b0;
    repeat (5) begin
      @(posedge cp);
      #1;
      acc = acc | tensig | onesig | !fault;
    end
    check("recover_stays", 128'(acc), 128'd0);
    refund(8'd5, 30, -1);
    check("r5_fault0", 128'(fault_m[0]), 128'd0);
    check("r5_ten", ten_m, 128'd0);
    check("r5_onecnt", 128'($countones(one_m)), 128'd10);
    check("r5_done", done_m, 128'd1 << 26);
    refund(8'd0, 5, -1);
    check("a0_done", done_m, 128'd1);
    check("a0_pulses", ten_m | one_m | busy_m, 128'd0);
    refund(8'd23, 30, 5);
    check23("poke");
    refund(8'd23, 7, -1);
    check("abort_pulse", 128'(ten_m[6]), 128'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_outs", 128'({tensig, onesig, busy, done, fault, remain}), 128'd0);
    @(negedge cp);
    rst = 1'b1;
    refund(8'd23, 30, -1);
    check23("rerun");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
